// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_e;

    localparam int unsigned           HIT_CNT_W   = 16;
    localparam logic [HIT_CNT_W-1:0]  HIT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cache_tag_match.sv
// Tag comparator: a line hits when it is valid and its stored tag equals the request tag.
module cache_tag_match #(
    parameter int unsigned TAG_W = 3
) (
    input  logic             valid_i,
    input  logic [TAG_W-1:0] stored_tag_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             hit_o
);

    assign hit_o = valid_i && (stored_tag_i == req_tag_i);

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// writeback/fetch/update miss FSM and a saturating hit counter.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned OFF_W  = 2,
    parameter int unsigned WORD_W = 8
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         READ,
    input  logic                         WRITE,
    input  logic [TAG_W+IDX_W+OFF_W-1:0] ADDRESS,
    input  logic [WORD_W-1:0]            WRITEDATA,
    output logic [WORD_W-1:0]            READDATA,
    output logic                         BUSYWAIT,
    output logic                         MEM_READ,
    output logic                         MEM_WRITE,
    output logic [TAG_W+IDX_W-1:0]       MEM_ADDRESS,
    output logic [WORD_W*(2**OFF_W)-1:0] MEM_WRITEDATA,
    input  logic [WORD_W*(2**OFF_W)-1:0] MEM_READDATA,
    input  logic                         MEM_BUSYWAIT,
    output logic [15:0]                  HIT_COUNT
);

    localparam int unsigned LINES = 2 ** IDX_W;
    localparam int unsigned BLK_W = WORD_W * (2 ** OFF_W);

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;

    assign off     = ADDRESS[OFF_W-1:0];
    assign idx     = ADDRESS[OFF_W +: IDX_W];
    assign req_tag = ADDRESS[OFF_W+IDX_W +: TAG_W];

    state_e               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // Tag and block storage carry no reset; valid bits guard their contents.
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [BLK_W-1:0] data_q [LINES];
    logic [BLK_W-1:0] data_d;
    logic             data_we;
    logic             tag_we;

    logic [BLK_W-1:0] cur_blk;
    logic [TAG_W-1:0] cur_tag;
    logic             hit;
    logic             req;
    logic             busy;

    assign cur_blk = data_q[idx];
    assign cur_tag = tag_q[idx];
    assign req     = READ || WRITE;

    cache_tag_match #(
        .TAG_W (TAG_W)
    ) u_tag_match (
        .valid_i      (valid_q[idx]),
        .stored_tag_i (cur_tag),
        .req_tag_i    (req_tag),
        .hit_o        (hit)
    );

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        hit_cnt_d     = hit_cnt_q;
        data_d        = cur_blk;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        busy          = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = {req_tag, idx};
        MEM_WRITEDATA = '0;
        READDATA      = '0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // READ and WRITE together are resolved as a write.
                        if (WRITE) begin
                            data_d[off*WORD_W +: WORD_W] = WRITEDATA;
                            data_we                      = 1'b1;
                            dirty_d[idx]                 = 1'b1;
                        end else begin
                            READDATA = cur_blk[off*WORD_W +: WORD_W];
                        end
                        if (hit_cnt_q != HIT_CNT_MAX) begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                        end
                    end else begin
                        busy    = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                busy          = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {cur_tag, idx};
                MEM_WRITEDATA = cur_blk;
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy         = 1'b1;
                data_d       = MEM_READDATA;
                data_we      = 1'b1;
                tag_we       = 1'b1;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // A miss request held through reset must not show a stall.
    assign BUSYWAIT  = busy && RESET_N;
    assign HIT_COUNT = hit_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (data_we) begin
            data_q[idx] <= data_d;
        end
        if (tag_we) begin
            tag_q[idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a 5-cycle block memory model.
module tb_dcache_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic [15:0] HIT_COUNT;

    int checks;
    int failures;

    dcache_ctrl u_dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .HIT_COUNT     (HIT_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: busy for the first four cycles of each request, ready on the fifth.
    logic [31:0] wmem    [64];
    logic [63:0] written;
    logic [2:0]  mem_cnt;
    logic        mem_req;

    function automatic logic [31:0] mem_init(input logic [5:0] a);
        case (a)
            6'h09:   mem_init = 32'hDDCCBBAA;
            6'h39:   mem_init = 32'h44332211;
            6'h3F:   mem_init = 32'h87654321;
            default: mem_init = {4{2'b00, a}};
        endcase
    endfunction

    assign mem_req      = MEM_READ || MEM_WRITE;
    assign MEM_BUSYWAIT = mem_req && (mem_cnt < 3'd4);
    assign MEM_READDATA = written[MEM_ADDRESS] ? wmem[MEM_ADDRESS] : mem_init(MEM_ADDRESS);

    always @(posedge CLK) begin
        if (mem_req && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 3'd1;
        else                         mem_cnt <= 3'd0;
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
            wmem[MEM_ADDRESS]    <= MEM_WRITEDATA;
            written[MEM_ADDRESS] <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last transaction.
    int          busy_cyc;
    int          rd_cyc;
    int          wr_cyc;
    int          overlap;
    logic [5:0]  rd_addr;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rdata;

    task automatic run_req(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata);
        int guard;
        busy_cyc = 0; rd_cyc = 0; wr_cyc = 0; overlap = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
        #1;
        guard = 0;
        while (BUSYWAIT && guard < 200) begin
            busy_cyc++;
            if (MEM_READ && MEM_WRITE) overlap++;
            if (MEM_READ) begin
                if (rd_cyc == 0) rd_addr = MEM_ADDRESS;
                rd_cyc++;
            end
            if (MEM_WRITE) begin
                if (wr_cyc == 0) begin
                    wr_addr = MEM_ADDRESS;
                    wr_data = MEM_WRITEDATA;
                end
                wr_cyc++;
            end
            @(negedge CLK);
            #1;
            guard++;
        end
        if (guard >= 200) check_eq("busywait_timeout", 32'(guard), 32'd0);
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        written = '0; mem_cnt = '0;
        READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check_eq("rst_mem_read", 32'(MEM_READ), 32'd0);
        check_eq("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check_eq("rst_readdata", 32'(READDATA), 32'd0);
        check_eq("rst_hit_count", 32'(HIT_COUNT), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Cold read miss: fetch only.
        run_req(1'b1, 1'b0, 8'h25, 8'h00);
        check_eq("cold_busy_cycles", 32'(busy_cyc), 32'd7);
        check_eq("cold_rd_cycles", 32'(rd_cyc), 32'd5);
        check_eq("cold_wr_cycles", 32'(wr_cyc), 32'd0);
        check_eq("cold_rd_addr", 32'(rd_addr), 32'h09);
        check_eq("cold_rdata", 32'(rdata), 32'hBB);
        check_eq("cold_hits", 32'(HIT_COUNT), 32'd1);

        run_req(1'b1, 1'b0, 8'h27, 8'h00);
        check_eq("hit_busy_cycles", 32'(busy_cyc), 32'd0);
        check_eq("hit_rdata", 32'(rdata), 32'hDD);
        check_eq("hit_hits", 32'(HIT_COUNT), 32'd2);

        run_req(1'b0, 1'b1, 8'h24, 8'h5A);
        check_eq("wr_hit_busy", 32'(busy_cyc), 32'd0);
        check_eq("wr_hit_mem_write", 32'(wr_cyc), 32'd0);
        run_req(1'b1, 1'b0, 8'h24, 8'h00);
        check_eq("wr_readback", 32'(rdata), 32'h5A);
        check_eq("wr_hits", 32'(HIT_COUNT), 32'd4);

        // Conflict on index 1 with a dirty victim: writeback then fetch.
        run_req(1'b1, 1'b0, 8'hE4, 8'h00);
        check_eq("conf_busy_cycles", 32'(busy_cyc), 32'd12);
        check_eq("conf_wr_cycles", 32'(wr_cyc), 32'd5);
        check_eq("conf_wr_addr", 32'(wr_addr), 32'h09);
        check_eq("conf_wr_data", wr_data, 32'hDDCCBB5A);
        check_eq("conf_rd_cycles", 32'(rd_cyc), 32'd5);
        check_eq("conf_rd_addr", 32'(rd_addr), 32'h39);
        check_eq("conf_overlap", 32'(overlap), 32'd0);
        check_eq("conf_rdata", 32'(rdata), 32'h11);
        check_eq("conf_hits", 32'(HIT_COUNT), 32'd5);

        // Reset while FETCH is in progress.
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h25;
        begin
            int g;
            g = 0;
            while (!MEM_READ && g < 20) begin
                @(negedge CLK);
                g++;
            end
            check_eq("abort_saw_fetch", 32'(MEM_READ), 32'd1);
        end
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_eq("abort_busywait", 32'(BUSYWAIT), 32'd0);
        check_eq("abort_mem_read", 32'(MEM_READ), 32'd0);
        check_eq("abort_hit_count", 32'(HIT_COUNT), 32'd0);
        @(negedge CLK);
        READ = 1'b0;
        RESET_N = 1'b1;

        run_req(1'b1, 1'b0, 8'h25, 8'h00);
        check_eq("rerun_busy_cycles", 32'(busy_cyc), 32'd7);
        check_eq("rerun_wr_cycles", 32'(wr_cyc), 32'd0);
        check_eq("rerun_rd_addr", 32'(rd_addr), 32'h09);
        check_eq("rerun_rdata", 32'(rdata), 32'hBB);
        check_eq("rerun_hits", 32'(HIT_COUNT), 32'd1);

        // Last index with all-ones tag, then evict it from a zero tag.
        run_req(1'b1, 1'b0, 8'hFF, 8'h00);
        check_eq("top_busy_cycles", 32'(busy_cyc), 32'd7);
        check_eq("top_rd_addr", 32'(rd_addr), 32'h3F);
        check_eq("top_rdata", 32'(rdata), 32'h87);
        run_req(1'b0, 1'b1, 8'hFE, 8'h99);
        check_eq("top_wr_busy", 32'(busy_cyc), 32'd0);
        run_req(1'b1, 1'b0, 8'hFE, 8'h00);
        check_eq("top_readback", 32'(rdata), 32'h99);
        run_req(1'b1, 1'b0, 8'h1C, 8'h00);
        check_eq("wrap_busy_cycles", 32'(busy_cyc), 32'd12);
        check_eq("wrap_wr_addr", 32'(wr_addr), 32'h3F);
        check_eq("wrap_wr_data", wr_data, 32'h87994321);
        check_eq("wrap_rd_addr", 32'(rd_addr), 32'h07);
        check_eq("wrap_rdata", 32'(rdata), 32'h07);
        check_eq("wrap_hits", 32'(HIT_COUNT), 32'd5);

        // Saturation: hold a read hit on line 1 for tens of thousands of cycles.
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h27;
        #1;
        check_eq("sat_no_stall", 32'(BUSYWAIT), 32'd0);
        repeat (65534 - 5) @(posedge CLK);
        #1;
        check_eq("sat_fffe", 32'(HIT_COUNT), 32'hFFFE);
        @(posedge CLK);
        #1;
        check_eq("sat_ffff", 32'(HIT_COUNT), 32'hFFFF);
        repeat (5) @(posedge CLK);
        #1;
        check_eq("sat_hold", 32'(HIT_COUNT), 32'hFFFF);
        READ = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
